// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell processes a+b+cin LSB first, one bit per clock,
// behind a start/ready/done handshake. sum/cout are registered and held between results.

module sa_half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module sa_full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s1;
    logic c1;
    logic c2;

    sa_half_adder u_ha0 (
        .a (a),
        .b (b),
        .s (s1),
        .c (c1)
    );

    sa_half_adder u_ha1 (
        .a (s1),
        .b (ci),
        .s (s),
        .c (c2)
    );

    // The two half-adder carries can never both be 1, so OR gives the majority.
    assign co = c1 | c2;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] psum_next;
    logic             carry;
    logic             bit_s;
    logic             bit_c;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             accept;

    sa_full_adder u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (bit_s),
        .co (bit_c)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign psum_next = (psum >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));
    assign last_bit  = (cnt == CW'(WIDTH - 1));
    assign accept    = (state == S_IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (last_bit) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            psum  <= '0;
            carry <= cin;
            cnt   <= '0;
        end else if (state == S_RUN) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            psum  <= psum_next;
            carry <= bit_c;
            cnt   <= cnt + CW'(1);
            // Result registers only move on the final bit; they hold across later runs.
            if (last_bit) begin
                sum  <= psum_next;
                cout <= bit_c;
            end
        end
    end

    assign ready = (state == S_IDLE);
    assign busy  = (state == S_RUN);
    assign done  = (state == S_DONE);
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: a WIDTH=8 instance with directed vectors and
// a WIDTH=1 instance swept over all operand combinations.

module tb_serial_adder;
    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_fail;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       ready8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       ready1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    logic [8:0] exp_q8[$];
    int         exp_cyc_q8[$];
    logic [1:0] exp_q1[$];
    int         exp_cyc_q1[$];

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .ready (ready8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .ready (ready1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    // Clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return ready8;
            1:       return busy8;
            default: return ready1;
        endcase
    endfunction

    // Called at a negedge; leaves the caller at the negedge where the condition holds.
    task automatic wait_for(input int sel, input logic val, input string nm);
        int t;
        t = 0;
        while (sig(sel) !== val && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: timeout waiting for level %0b", nm, val);
        end
    endtask

    task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] es, input logic ec);
        wait_for(0, 1'b1, "ready8_wait");
        a8     = a;
        b8     = b;
        cin8   = c;
        start8 = 1'b1;
        exp_q8.push_back({ec, es});
        exp_cyc_q8.push_back(cyc + 1 + 8);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic add1(input logic a, input logic b, input logic c, input logic [1:0] e);
        wait_for(2, 1'b1, "ready1_wait");
        a1     = a;
        b1     = b;
        cin1   = c;
        start1 = 1'b1;
        exp_q1.push_back(e);
        exp_cyc_q1.push_back(cyc + 1 + 1);
        @(negedge clk);
        start1 = 1'b0;
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        logic [8:0] e;
        int         ec;
        if (done8) begin
            if (exp_q8.size() == 0) begin
                chk("done8_unexpected", 32'(done8), 32'd0);
            end else begin
                e  = exp_q8.pop_front();
                ec = exp_cyc_q8.pop_front();
                chk("result8", 32'({cout8, sum8}), 32'(e));
                chk("latency8", 32'(cyc), 32'(ec));
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0] e;
        int         ec;
        if (done1) begin
            if (exp_q1.size() == 0) begin
                chk("done1_unexpected", 32'(done1), 32'd0);
            end else begin
                e  = exp_q1.pop_front();
                ec = exp_cyc_q1.pop_front();
                chk("result1", 32'({cout1, sum1}), 32'(e));
                chk("latency1", 32'(cyc), 32'(ec));
            end
        end
    end

    // Directed vectors: {a, b, cin, sum, cout}
    logic [25:0] vec8[4];
    int          t1;
    int          t2;
    int          k;

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        vec8[0] = {8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vec8[1] = {8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vec8[2] = {8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        vec8[3] = {8'h3C, 8'h41, 1'b0, 8'h7D, 1'b0};

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(ready8), 32'd1);
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_sum", 32'(sum8), 32'h00);
        chk("rst_cout", 32'(cout8), 32'd0);

        for (int i = 0; i < 4; i++) begin
            add8(vec8[i][25:18], vec8[i][17:10], vec8[i][9], vec8[i][8:1], vec8[i][0]);
        end

        // start held high; operands change mid-run and only affect the next accept
        wait_for(0, 1'b1, "ready8_wait");
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        k = cyc;
        exp_q8.push_back({1'b0, 8'h30});
        exp_cyc_q8.push_back(k + 1 + 8);
        exp_q8.push_back({1'b0, 8'h02});
        exp_cyc_q8.push_back(k + 11 + 8);
        @(negedge clk);
        wait_for(1, 1'b1, "busy8_first");
        t1 = cyc;
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h01;
        wait_for(1, 1'b0, "busy8_fall");
        wait_for(1, 1'b1, "busy8_second");
        t2 = cyc;
        start8 = 1'b0;
        chk("reaccept_gap", 32'(t2 - t1), 32'd10);

        // Abort mid-run with reset
        wait_for(0, 1'b1, "ready8_wait");
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("hold_sum_in_run", 32'(sum8), 32'h02);
        chk("busy_in_run", 32'(busy8), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(ready8), 32'd1);
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_sum", 32'(sum8), 32'h00);
        chk("abort_cout", 32'(cout8), 32'd0);
        add8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        // WIDTH=1: all operand combinations
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            add1(v[2], v[1], v[0], 2'(v[2]) + 2'(v[1]) + 2'(v[0]));
        end

        for (int t = 0; t < 60 && (exp_q8.size() != 0 || exp_q1.size() != 0); t++) begin
            @(negedge clk);
        end
        while (exp_q8.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL missing_done8: got none expected 0x%0h", exp_q8.pop_front());
        end
        while (exp_q1.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL missing_done1: got none expected 0x%0h", exp_q1.pop_front());
        end
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
